// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: PC width, reset vector, bundle width and
// the next-PC sequencer state encodings.
package fetch_pkg;

   localparam int PC_W        = 16;
   localparam int FETCH_WIDTH = 4;

   localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
   localparam logic [PC_W-1:0] PC_INC   = PC_W'(FETCH_WIDTH);

   localparam logic [1:0] RUN     = 2'b00;
   localparam logic [1:0] JR_WAIT = 2'b01;
   localparam logic [1:0] LOOP    = 2'b10;

   // Sequential advance by one bundle; wraps modulo 2^PC_W.
   function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
      return pc + PC_INC;
   endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Redirect/feedback bundle between ROB, ID, RF, predictor and the fetch PC
// sequencer; master drives requests, slave is the sequencer.
interface fetch_pc_ctrl_if;
   import fetch_pkg::*;

   logic            exter_pc_en;
   logic [PC_W-1:0] exter_pc;
   logic            has_mispredict;
   logic [PC_W-1:0] pc_recovery;
   logic            loop_start;
   logic            loop_exit;
   logic [PC_W-1:0] loop_exit_pc;
   logic            jr_req;
   logic            jump_base_rdy_from_rf;
   logic [PC_W-1:0] jump_base_from_rf;
   logic            pred_taken;
   logic [PC_W-1:0] pred_target;
   logic            stall_fetch;
   logic [PC_W-1:0] pc_out;
   logic            fetch_vld;
   logic            if_id_stall;
   logic            if_id_flush;
   logic [1:0]      state_out;

   modport master (
      output exter_pc_en, exter_pc, has_mispredict, pc_recovery,
             loop_start, loop_exit, loop_exit_pc, jr_req,
             jump_base_rdy_from_rf, jump_base_from_rf,
             pred_taken, pred_target, stall_fetch,
      input  pc_out, fetch_vld, if_id_stall, if_id_flush, state_out
   );

   modport slave (
      input  exter_pc_en, exter_pc, has_mispredict, pc_recovery,
             loop_start, loop_exit, loop_exit_pc, jr_req,
             jump_base_rdy_from_rf, jump_base_from_rf,
             pred_taken, pred_target, stall_fetch,
      output pc_out, fetch_vld, if_id_stall, if_id_flush, state_out
   );

endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register and redirect arbiter: picks the next bundle address and
// drives the IF_ID stall/flush controls.
module fetch_pc_ctrl
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   fetch_pc_ctrl_if.slave  pc_if
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [1:0]      state_q, state_d;
   logic            jr_req_unresolved;
   logic            flush;

   assign jr_req_unresolved = pc_if.jr_req & ~pc_if.jump_base_rdy_from_rf;

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      if (pc_if.exter_pc_en) begin
         pc_d    = pc_if.exter_pc;
         state_d = RUN;
      end else if (pc_if.has_mispredict) begin
         pc_d    = pc_if.pc_recovery;
         state_d = RUN;
      end else begin
         case (state_q)
            LOOP: begin
               if (pc_if.loop_exit) begin
                  pc_d    = pc_if.loop_exit_pc;
                  state_d = RUN;
               end
            end
            JR_WAIT: begin
               if (pc_if.jump_base_rdy_from_rf) begin
                  pc_d    = pc_if.jump_base_from_rf;
                  state_d = RUN;
               end
            end
            RUN: begin
               // Redirects above stall; stall only gates the advance paths.
               if (pc_if.loop_start) begin
                  state_d = LOOP;
               end else if (pc_if.jr_req) begin
                  if (pc_if.jump_base_rdy_from_rf) begin
                     pc_d = pc_if.jump_base_from_rf;
                  end else begin
                     state_d = JR_WAIT;
                  end
               end else if (!pc_if.stall_fetch) begin
                  if (pc_if.pred_taken) begin
                     pc_d = pc_if.pred_target;
                  end else begin
                     pc_d = next_seq_pc(pc_q);
                  end
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         state_q <= RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   assign flush = pc_if.exter_pc_en | pc_if.has_mispredict |
                  ((state_q == RUN) & pc_if.loop_start);

   assign pc_if.pc_out      = pc_q;
   assign pc_if.state_out   = state_q;
   assign pc_if.if_id_flush = flush;
   assign pc_if.if_id_stall = pc_if.stall_fetch & ~flush;
   assign pc_if.fetch_vld   = (state_q == RUN) & ~pc_if.stall_fetch &
                              ~pc_if.exter_pc_en & ~pc_if.has_mispredict &
                              ~jr_req_unresolved;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl: reset, sequential advance,
// JR wait/resolve, loop handoff, wrap, stall and redirect priorities.
module tb_fetch_pc_ctrl;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   fetch_pc_ctrl_if pc_if ();

   fetch_pc_ctrl u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pc_if (pc_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      pc_if.exter_pc_en           = 1'b0;
      pc_if.exter_pc              = 16'h0000;
      pc_if.has_mispredict        = 1'b0;
      pc_if.pc_recovery           = 16'h0000;
      pc_if.loop_start            = 1'b0;
      pc_if.loop_exit             = 1'b0;
      pc_if.loop_exit_pc          = 16'h0000;
      pc_if.jr_req                = 1'b0;
      pc_if.jump_base_rdy_from_rf = 1'b0;
      pc_if.jump_base_from_rf     = 16'h0000;
      pc_if.pred_taken            = 1'b0;
      pc_if.pred_target           = 16'h0000;
      pc_if.stall_fetch           = 1'b0;
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_pc(input logic [15:0] pc);
      clear_inputs();
      pc_if.exter_pc_en = 1'b1;
      pc_if.exter_pc    = pc;
      tick();
      clear_inputs();
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      #3;
      n_cmp++;
      if (pc_if.pc_out !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL reset_pc: got %h expected %h", pc_if.pc_out, 16'h0000);
      end
      n_cmp++;
      if (pc_if.state_out !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL reset_state: got %b expected %b", pc_if.state_out, 2'b00);
      end
      n_cmp++;
      if ({pc_if.fetch_vld, pc_if.if_id_stall, pc_if.if_id_flush} !== 3'b100) begin
         n_fail++;
         $display("[TB] FAIL reset_ctrl: got %b expected %b",
                  {pc_if.fetch_vld, pc_if.if_id_stall, pc_if.if_id_flush}, 3'b100);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_cmp++;
         if (pc_if.pc_out !== 16'(4 * i) || pc_if.fetch_vld !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL seq_advance[%0d]: got pc %h vld %b expected pc %h vld 1",
                     i, pc_if.pc_out, pc_if.fetch_vld, 16'(4 * i));
         end
      end
   endtask

   task automatic test_jr_wait();
      load_pc(16'h0010);
      pc_if.jr_req = 1'b1;
      #1;
      n_cmp++;
      if (pc_if.fetch_vld !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL jr_unresolved_vld: got %b expected 0", pc_if.fetch_vld);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (pc_if.state_out !== 2'b01 || pc_if.pc_out !== 16'h0010 || pc_if.fetch_vld !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL jr_wait_hold[%0d]: got st %b pc %h vld %b expected st 01 pc 0010 vld 0",
                     i, pc_if.state_out, pc_if.pc_out, pc_if.fetch_vld);
         end
      end
      pc_if.jump_base_rdy_from_rf = 1'b1;
      pc_if.jump_base_from_rf     = 16'h0200;
      tick();
      clear_inputs();
      #1;
      n_cmp++;
      if (pc_if.pc_out !== 16'h0200 || pc_if.state_out !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL jr_resolve: got pc %h st %b expected pc 0200 st 00",
                  pc_if.pc_out, pc_if.state_out);
      end
   endtask

   task automatic test_jr_immediate_under_stall();
      load_pc(16'h0020);
      pc_if.jr_req                = 1'b1;
      pc_if.jump_base_rdy_from_rf = 1'b1;
      pc_if.jump_base_from_rf     = 16'h0302;
      pc_if.stall_fetch           = 1'b1;
      tick();
      clear_inputs();
      #1;
      n_cmp++;
      if (pc_if.pc_out !== 16'h0302 || pc_if.state_out !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL jr_immediate: got pc %h st %b expected pc 0302 st 00",
                  pc_if.pc_out, pc_if.state_out);
      end
   endtask

   task automatic test_jr_mispredict();
      load_pc(16'h0200);
      pc_if.jr_req = 1'b1;
      tick();
      pc_if.jr_req         = 1'b0;
      pc_if.has_mispredict = 1'b1;
      pc_if.pc_recovery    = 16'h0040;
      #1;
      n_cmp++;
      if (pc_if.if_id_flush !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL mispredict_flush: got %b expected 1", pc_if.if_id_flush);
      end
      tick();
      clear_inputs();
      #1;
      n_cmp++;
      if (pc_if.pc_out !== 16'h0040 || pc_if.state_out !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL mispredict_in_jr: got pc %h st %b expected pc 0040 st 00",
                  pc_if.pc_out, pc_if.state_out);
      end
   endtask

   task automatic test_loop();
      load_pc(16'h0100);
      pc_if.loop_start = 1'b1;
      #1;
      n_cmp++;
      if (pc_if.if_id_flush !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL loop_start_flush: got %b expected 1", pc_if.if_id_flush);
      end
      tick();
      // loop_start stays high and a predicted branch is offered; both must be ignored.
      pc_if.pred_taken  = 1'b1;
      pc_if.pred_target = 16'h0999;
      #1;
      n_cmp++;
      if (pc_if.if_id_flush !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL loop_restart_flush: got %b expected 0", pc_if.if_id_flush);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (pc_if.state_out !== 2'b10 || pc_if.pc_out !== 16'h0100 || pc_if.fetch_vld !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL loop_hold[%0d]: got st %b pc %h vld %b expected st 10 pc 0100 vld 0",
                     i, pc_if.state_out, pc_if.pc_out, pc_if.fetch_vld);
         end
      end
      clear_inputs();
      pc_if.loop_exit    = 1'b1;
      pc_if.loop_exit_pc = 16'h0120;
      tick();
      clear_inputs();
      #1;
      n_cmp++;
      if (pc_if.pc_out !== 16'h0120 || pc_if.state_out !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL loop_exit: got pc %h st %b expected pc 0120 st 00",
                  pc_if.pc_out, pc_if.state_out);
      end
      pc_if.loop_start = 1'b1;
      tick();
      pc_if.loop_start     = 1'b0;
      pc_if.loop_exit      = 1'b1;
      pc_if.loop_exit_pc   = 16'h0130;
      pc_if.has_mispredict = 1'b1;
      pc_if.pc_recovery    = 16'h0044;
      tick();
      clear_inputs();
      #1;
      n_cmp++;
      if (pc_if.pc_out !== 16'h0044 || pc_if.state_out !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL loop_exit_vs_mispredict: got pc %h st %b expected pc 0044 st 00",
                  pc_if.pc_out, pc_if.state_out);
      end
   endtask

   task automatic test_wrap_and_stall();
      load_pc(16'hFFFC);
      tick();
      n_cmp++;
      if (pc_if.pc_out !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL pc_wrap: got %h expected 0000", pc_if.pc_out);
      end
      load_pc(16'hFFFC);
      pc_if.stall_fetch = 1'b1;
      pc_if.pred_taken  = 1'b1;
      pc_if.pred_target = 16'h1234;
      #1;
      n_cmp++;
      if ({pc_if.if_id_stall, pc_if.if_id_flush, pc_if.fetch_vld} !== 3'b100) begin
         n_fail++;
         $display("[TB] FAIL stall_ctrl: got stall/flush/vld %b expected 100",
                  {pc_if.if_id_stall, pc_if.if_id_flush, pc_if.fetch_vld});
      end
      tick();
      n_cmp++;
      if (pc_if.pc_out !== 16'hFFFC) begin
         n_fail++;
         $display("[TB] FAIL stall_hold: got %h expected FFFC", pc_if.pc_out);
      end
      pc_if.stall_fetch = 1'b0;
      tick();
      clear_inputs();
      #1;
      n_cmp++;
      if (pc_if.pc_out !== 16'h1234) begin
         n_fail++;
         $display("[TB] FAIL pred_taken: got %h expected 1234", pc_if.pc_out);
      end
   endtask

   task automatic test_exter_priority();
      load_pc(16'h0500);
      pc_if.exter_pc_en    = 1'b1;
      pc_if.exter_pc       = 16'h0800;
      pc_if.has_mispredict = 1'b1;
      pc_if.pc_recovery    = 16'h0040;
      pc_if.stall_fetch    = 1'b1;
      #1;
      n_cmp++;
      if ({pc_if.if_id_flush, pc_if.if_id_stall, pc_if.fetch_vld} !== 3'b100) begin
         n_fail++;
         $display("[TB] FAIL exter_ctrl: got flush/stall/vld %b expected 100",
                  {pc_if.if_id_flush, pc_if.if_id_stall, pc_if.fetch_vld});
      end
      tick();
      clear_inputs();
      #1;
      n_cmp++;
      if (pc_if.pc_out !== 16'h0800 || pc_if.state_out !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL exter_priority: got pc %h st %b expected pc 0800 st 00",
                  pc_if.pc_out, pc_if.state_out);
      end
   endtask

   task automatic test_reset_mid_state();
      load_pc(16'h0600);
      pc_if.jr_req = 1'b1;
      tick();
      clear_inputs();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (pc_if.pc_out !== 16'h0000 || pc_if.state_out !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_jr: got pc %h st %b expected pc 0000 st 00",
                  pc_if.pc_out, pc_if.state_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (pc_if.pc_out !== 16'h0004 || pc_if.state_out !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL reset_release: got pc %h st %b expected pc 0004 st 00",
                  pc_if.pc_out, pc_if.state_out);
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b1;
      clear_inputs();
      #2;
      test_reset();
      test_jr_wait();
      test_jr_immediate_under_stall();
      test_jr_mispredict();
      test_loop();
      test_wrap_and_stall();
      test_exter_priority();
      test_reset_mid_state();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
